mem_io_responder: RTL

// - Responder end of the CPU byte bus (mem_a/mem_wr/CPU data out/CPU data in/io_buffer_full).
// - Holds the 128KB unified RAM and the I/O window at mem_a[17:16]==2'b11: UART TX/RX byte queues, cycle counter, program-stop flag.
// - Sits beside cpu at the system top level. Read data is returned the cycle after the address; writes complete in one cycle.

---
 rtl/mem_io_responder_pkg.sv | 9 +
 rtl/mem_io_responder_byte_fifo.sv | 53 +++++
 rtl/mem_io_responder.sv | 113 +++++++++++
 3 files changed

// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg: shared bus widths and I/O window addresses for the CPU byte bus responder
package mem_io_responder_pkg;
    localparam int          BUS_AW  = 18;
    localparam int          DATA_W  = 8;
    localparam logic [17:0] IO_BASE = 18'h30000;
    localparam logic [17:0] IO_UART = 18'h30000;
    localparam logic [17:0] IO_CLK  = 18'h30004;
    localparam logic [1:0]  IO_SEL  = IO_BASE[17:16];
endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// byte_fifo: single-clock byte queue with occupancy count
// Ports: clk/rst (async active-high), push/din enqueue, pop dequeue head,
//        dout = head byte, full/empty flags, count = current occupancy,
//        next_count = occupancy after this cycle's push/pop.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   next_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;

    assign empty      = count == '0;
    assign full       = count == CW'(DEPTH);
    assign dout       = mem[rp];
    assign do_pop     = pop && !empty;
    // A push into a full queue only fits if the head leaves in the same cycle.
    assign do_push    = push && (!full || do_pop);
    assign next_count = count + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            count <= next_count;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    always @(posedge clk) begin
        if (!rst) assert (!(push && !do_push)) else $warning("byte_fifo: push dropped while full");
    end
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU byte-bus responder holding unified RAM, UART queues, cycle counter and stop flag
// Ports: clk_in/rst_in (async active-high), rdy_in bus qualifier, mem_a/mem_wr/mem_dout
//        request, mem_din registered read data, io_buffer_full TX near-full,
//        tx_valid/tx_data/tx_ready UART transmit, rx_valid/rx_data/rx_ready UART receive,
//        program_stop sticky stop flag.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_W  = 17,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [31:0]       mem_a,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] mem_din,
    output logic              io_buffer_full,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              program_stop
);
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    localparam logic [TX_CW-1:0] FULL_LVL = TX_CW'(TX_DEPTH - FULL_MARGIN);

    logic [DATA_W-1:0] ram [2**RAM_ADDR_W];
    logic [BUS_AW-1:0] addr;
    logic              unused_hi;
    logic              is_io, is_ram, rd, wr, uart_wr, stop_wr;
    logic              tx_push, tx_empty, rx_pop, rx_full, rx_empty;
    logic [DATA_W-1:0] tx_din, rx_head, io_rd, rd_data;
    logic [31:0]       counter, snapshot;
    logic [TX_CW-1:0]  tx_next_count, unused_tx_count;
    logic [RX_CW-1:0]  unused_rx_count, unused_rx_next;
    logic              unused_tx_full;

    assign addr      = mem_a[BUS_AW-1:0];
    assign unused_hi = ^mem_a[31:BUS_AW];
    assign is_io     = addr[17:16] == IO_SEL;
    assign is_ram    = !addr[17];
    assign rd        = rdy_in && !mem_wr;
    assign wr        = rdy_in && mem_wr && !program_stop;
    assign uart_wr   = wr && addr == IO_UART;
    assign stop_wr   = wr && addr == IO_CLK;
    // A zero byte written to the UART port is treated as "nothing to send".
    assign tx_push   = (uart_wr && mem_dout != '0) || stop_wr;
    assign tx_din    = stop_wr ? '0 : mem_dout;
    assign rx_pop    = rd && addr == IO_UART;
    assign tx_valid  = !tx_empty;
    assign rx_ready  = !rx_full;

    // Upper counter bytes come from the snapshot taken by the low-byte read,
    // so a multi-byte read sees one coherent value.
    assign io_rd   = addr == IO_UART                ? (rx_empty ? '0 : rx_head)
                   : addr == IO_CLK                 ? counter[7:0]
                   : addr[17:2] == IO_CLK[17:2]     ? snapshot[{addr[1:0], 3'b000} +: 8]
                   : '0;
    assign rd_data = is_ram ? ram[addr[RAM_ADDR_W-1:0]] : is_io ? io_rd : '0;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din        <= '0;
            io_buffer_full <= 1'b0;
            program_stop   <= 1'b0;
            counter        <= '0;
            snapshot       <= '0;
        end else begin
            counter        <= counter + 32'd1;
            io_buffer_full <= tx_next_count >= FULL_LVL;
            if (rd) mem_din <= rd_data;
            if (rd && addr == IO_CLK) snapshot <= counter;
            if (stop_wr) program_stop <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr && is_ram) ram[addr[RAM_ADDR_W-1:0]] <= mem_dout;
    end

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx (
        .clk        (clk_in),
        .rst        (rst_in),
        .push       (tx_push),
        .pop        (tx_ready),
        .din        (tx_din),
        .dout       (tx_data),
        .full       (unused_tx_full),
        .empty      (tx_empty),
        .count      (unused_tx_count),
        .next_count (tx_next_count)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx (
        .clk        (clk_in),
        .rst        (rst_in),
        .push       (rx_valid),
        .pop        (rx_pop),
        .din        (rx_data),
        .dout       (rx_head),
        .full       (rx_full),
        .empty      (rx_empty),
        .count      (unused_rx_count),
        .next_count (unused_rx_next)
    );
endmodule
